// File: rtl/cic_comb_decimator.sv
// cic_comb_decimator: decimating comb section of a CIC decimator with priming and scaled output
module cic_comb_decimator #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int STAGES     = 3,
    parameter int DIFF_DELAY = 1,
    parameter int OUT_SHIFT  = 16,
    parameter int RATE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_valid,
    input  logic [IN_WIDTH-1:0]   s_data,
    input  logic [RATE_WIDTH-1:0] decim_rate,
    output logic                  m_valid,
    output logic [OUT_WIDTH-1:0]  m_data,
    output logic                  primed
);
    localparam int P  = STAGES * DIFF_DELAY;
    localparam int PW = $clog2(P + 1);

    logic [RATE_WIDTH-1:0] rate_q, rate_d, cnt_q, cnt_d;
    logic                  hit;
    // st_q[0] is the input capture register; st_q[k+1] is the output of comb stage k
    logic [IN_WIDTH-1:0]   st_q [STAGES+1];
    logic [IN_WIDTH-1:0]   st_d [STAGES+1];
    logic [STAGES:0]       st_v_q, st_v_d;
    logic [IN_WIDTH-1:0]   dl_q [STAGES][DIFF_DELAY];
    logic [IN_WIDTH-1:0]   dl_d [STAGES][DIFF_DELAY];
    logic [PW-1:0]         pc_q, pc_d;
    logic [OUT_WIDTH-1:0]  sc_q, sc_d, m_data_q, m_data_d;
    logic                  sc_v_q, sc_v_d, m_valid_q, m_valid_d, primed_q, primed_d;

    // decimation: keep the sample that closes each window, relatch the rate on every hit
    always_comb begin
        hit    = s_valid && (rate_q <= RATE_WIDTH'(1) || cnt_q == rate_q - RATE_WIDTH'(1));
        cnt_d  = s_valid ? (hit ? '0 : cnt_q + RATE_WIDTH'(1)) : cnt_q;
        rate_d = hit ? decim_rate : rate_q;
    end

    // comb stages: delay lines advance only with the valid bit travelling through each stage
    always_comb begin
        st_d      = st_q;
        dl_d      = dl_q;
        st_v_d[0] = hit;
        st_d[0]   = hit ? s_data : st_q[0];
        for (int k = 0; k < STAGES; k++) begin
            st_v_d[k+1] = st_v_q[k];
            if (st_v_q[k]) begin
                st_d[k+1] = st_q[k] - dl_q[k][DIFF_DELAY-1];
                dl_d[k][0] = st_q[k];
                for (int j = 1; j < DIFF_DELAY; j++) dl_d[k][j] = dl_q[k][j-1];
            end
        end
    end

    // priming gate, arithmetic scaling and held output register
    always_comb begin
        pc_d   = pc_q;
        sc_v_d = 1'b0;
        if (st_v_q[STAGES]) begin
            if (pc_q == PW'(P)) sc_v_d = 1'b1;
            else pc_d = pc_q + PW'(1);
        end
        sc_d      = sc_v_d ? OUT_WIDTH'($signed(st_q[STAGES]) >>> OUT_SHIFT) : sc_q;
        m_valid_d = sc_v_q;
        m_data_d  = sc_v_q ? sc_q : m_data_q;
        primed_d  = primed_q | sc_v_q;
    end

    // state registers; the rate follows decim_rate while held in reset so release latches it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rate_q    <= decim_rate;
            cnt_q     <= '0;
            st_q      <= '{default: '0};
            st_v_q    <= '0;
            dl_q      <= '{default: '{default: '0}};
            pc_q      <= '0;
            sc_q      <= '0;
            sc_v_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            primed_q  <= 1'b0;
        end else begin
            rate_q    <= rate_d;
            cnt_q     <= cnt_d;
            st_q      <= st_d;
            st_v_q    <= st_v_d;
            dl_q      <= dl_d;
            pc_q      <= pc_d;
            sc_q      <= sc_d;
            sc_v_q    <= sc_v_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            primed_q  <= primed_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign primed  = primed_q;
endmodule

// File: doc/cic_comb_decimator.md
Name: cic_comb_decimator

Overview:
- Decimating comb (differentiator) section of a CIC decimator. Sits downstream of the integrator cascade in the ADC capture path.
- Accepts the integrator-chain output, keeps one sample in every decim_rate, and runs STAGES registered comb stages, y[n] = x[n] - x[n-DIFF_DELAY], at the low rate.
- Emits a scaled, truncated, valid-qualified output stream toward the AXI-Stream packer.

Parameters:
IN_WIDTH, 32, width of integrator-chain samples and of all comb arithmetic
OUT_WIDTH, 16, output sample width
STAGES, 3, number of comb stages (1..8)
DIFF_DELAY, 1, differential delay M per stage (1 or 2)
OUT_SHIFT, 16, arithmetic right shift applied before truncation (0..IN_WIDTH-OUT_WIDTH)
RATE_WIDTH, 16, width of the decim_rate input

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
s_valid  in  1  input sample strobe, one sample per high cycle
s_data  in  IN_WIDTH  signed integrator-chain output
decim_rate  in  RATE_WIDTH  runtime decimation ratio R; 0 and 1 both mean pass every sample
m_valid  out  1  single-cycle output strobe
m_data  out  OUT_WIDTH  signed decimated, combed, scaled sample
primed  out  1  high once comb delay lines hold real data

Behaviour:
- Reset (reset_n low at a clock edge):
  - Clears decimation counter, prime counter, all delay-line registers, all pipeline registers and valid bits.
  - m_valid=0, m_data=0, primed=0.
  - Reset applied mid-operation discards every in-flight sample; no m_valid pulse follows for data accepted before reset.
- Rate latch: R_active is loaded from decim_rate at reset release and at every decimation hit. A change of decim_rate between hits takes effect only after the next hit.
- Decimation counter:
  - Counts accepted s_valid samples from 0 to R_active-1.
  - A hit is an s_valid sample arriving while counter == R_active-1, or any s_valid sample when R_active <= 1.
  - On a hit the counter returns to 0 and the sample is captured into the input register. All other samples are dropped.
  - Cycles with s_valid low change nothing.
- Comb stages:
  - Stage k computes in[k] - delay_k[DIFF_DELAY-1], then shifts its delay line.
  - Delay lines advance only on the valid bit travelling with that stage, never on idle cycles.
  - All subtraction is modulo 2^IN_WIDTH two's complement, with no saturation. Integrator wrap-around must cancel exactly, so no extra bits are added.
- Pipeline and latency:
  - One register for input capture, one register per stage, one output register.
  - m_valid asserts exactly STAGES+2 clock edges after the edge that samples the hit s_valid; m_data is valid in the same cycle.
  - Throughput is one hit per cycle (R=1 with continuous s_valid gives continuous m_valid after priming).
- Scaling: m_data = bits [OUT_WIDTH-1:0] of (comb_out >>> OUT_SHIFT). The shift is arithmetic; truncation drops the LSBs without rounding.
- Priming:
  - A prime counter counts hits up to STAGES*DIFF_DELAY.
  - Output for the first STAGES*DIFF_DELAY hits after reset is suppressed (m_valid stays 0; m_data holds its last value).
  - primed rises together with the first unsuppressed m_valid and stays high until reset.
- m_data holds its value between m_valid pulses. There is no backpressure; downstream must accept every pulse.

Test Plan:
1. Ramp, IN=OUT=16, SHIFT=0, STAGES=1, M=1, R=4: s_valid continuous, s_data=0,1,2,... -> captured samples 3,7,11,...; first hit suppressed; then m_data=4 on every m_valid; m_valid spacing 4 cycles; first m_valid 3 edges after the s_data=7 edge.
2. Wrap-around, same config, R=1: s_data=32766,32767,-32768,-32767 -> after priming, m_data=1,1,1; no sign errors across the wrap.
3. Step, IN=OUT=16, STAGES=3, M=1, R=1: s_data=0,0,5,5,5,5,5 -> first three hits suppressed; then m_data=-10,5,0,0; primed rises with the -10 pulse.
4. Rate change: R=4 running, decim_rate set to 2 mid-window -> current window still closes after 4 samples; subsequent m_valid spacing is 2 samples; decim_rate=0 -> every sample passes.
5. Reset mid-operation: assert reset_n=0 for one edge while samples are in the pipeline -> no m_valid for 2*STAGES+2 cycles after release; primed=0; m_data=0; priming restarts from zero.
6. Gapped input plus scaling, OUT_SHIFT=4, OUT_WIDTH=8, STAGES=1, R=2: s_valid toggles every other cycle with s_data=0,32,64,... -> delay lines step only on hits; m_data=(64>>>4)=4 per output.
